// File: rtl/rol_seq.sv
// rol_seq: multi-cycle rotate-left unit. Rotates DATA left by AMOUNT[AMT_W-1:0]
// positions, one position per clock, behind a START/BUSY/DONE handshake.
// OUT holds the last completed result; DONE strobes for one cycle when OUT updates.
module rol_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA,
  input  logic [7:0]       AMOUNT,
  output logic [WIDTH-1:0] OUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   wr, wr_nxt;
  logic [AMT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   out_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [AMT_W-1:0]   amt;
  logic [WIDTH-1:0]   wr_rol;

  // Only the low AMT_W bits of AMOUNT matter; larger counts alias onto them.
  assign amt    = AMOUNT[AMT_W-1:0];
  assign wr_rol = {wr[WIDTH-2:0], wr[WIDTH-1]};

  logic unused_amount;
  assign unused_amount = ^AMOUNT[7:AMT_W];

  // Next-state and next-output logic; BUSY/DONE are derived from the next state
  // so that both leave the block as plain flops.
  always_comb begin
    state_nxt = state;
    wr_nxt    = wr;
    cnt_nxt   = cnt;
    out_nxt   = OUT;
    case (state)
      IDLE: begin
        if (START) begin
          wr_nxt  = DATA;
          cnt_nxt = amt;
          if (amt != '0) begin
            state_nxt = ROTATE;
          end else begin
            out_nxt   = DATA;
            state_nxt = FINISH;
          end
        end
      end
      ROTATE: begin
        wr_nxt  = wr_rol;
        cnt_nxt = cnt - AMT_W'(1);
        // The last rotate step publishes its result directly, so CNT never wraps.
        if (cnt == AMT_W'(1)) begin
          out_nxt   = wr_rol;
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FINISH);
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      wr    <= '0;
      cnt   <= '0;
      OUT   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      wr    <= wr_nxt;
      cnt   <= cnt_nxt;
      OUT   <= out_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rol_seq.sv
// Testbench for rol_seq: directed operations push hand-computed results into a
// scoreboard queue; a monitor pops on every DONE and checks value and timing.
module tb_rol_seq;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA;
  logic [7:0] AMOUNT;
  logic [7:0] OUT;
  logic       BUSY;
  logic       DONE;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         failures;
  int         cyc;
  int         done_cnt;
  logic [7:0] last_out;

  rol_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .DATA   (DATA),
    .AMOUNT (AMOUNT),
    .OUT    (OUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  // 10 time-unit clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Edge counter: at the negedge after posedge number k, cyc reads k.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every DONE must match the head of the scoreboard, on its due edge;
  // OUT must stay put on every other cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      last_out = 8'h00;
    end else if (DONE === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got OUT=%0h with empty scoreboard (cycle %0d)", OUT, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_out", OUT, e.val);
        check("done_cycle", cyc, e.due);
        last_out = e.val;
      end
    end else begin
      check("out_stable", OUT, last_out);
    end
  end

  // Issue one operation, expect result exp, and verify BUSY spans a+1 sampled cycles.
  task automatic do_op(input logic [7:0] d, input logic [7:0] amt, input logic [7:0] exp);
    exp_t e;
    int   busy_cnt;
    int   n;
    @(negedge CLK);
    START  = 1'b1;
    DATA   = d;
    AMOUNT = amt;
    e.val  = exp;
    e.due  = cyc + 1 + int'(amt[2:0]);
    sb.push_back(e);
    @(negedge CLK);
    START  = 1'b0;
    DATA   = 8'($urandom);
    AMOUNT = 8'($urandom);
    busy_cnt = 0;
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      busy_cnt++;
      n++;
      @(negedge CLK);
    end
    check("busy_len", busy_cnt, int'(amt[2:0]) + 1);
    check("drained", sb.size(), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    done_cnt = 0;
    last_out = 8'h00;
    RESET    = 1'b0;
    START    = 1'b0;
    DATA     = 8'h00;
    AMOUNT   = 8'h00;

    // START during reset must do nothing.
    #2;
    check("rst_out", OUT, 8'h00);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    START  = 1'b1;
    DATA   = 8'h55;
    AMOUNT = 8'h01;
    repeat (3) @(negedge CLK);
    check("rst_start_busy", BUSY, 1'b0);
    check("rst_start_out", OUT, 8'h00);
    START = 1'b0;
    RESET = 1'b1;

    // Idle for 10 cycles after release.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_busy", BUSY, 1'b0);
      check("idle_done", DONE, 1'b0);
    end

    // Basic rotates and amount edge cases.
    do_op(8'h81, 8'h01, 8'h03);
    do_op(8'hB4, 8'h03, 8'hA5);
    do_op(8'h3C, 8'h00, 8'h3C);
    do_op(8'h01, 8'h07, 8'h80);
    do_op(8'h96, 8'h0A, 8'h5A);

    // Busy lockout: second START during ROTATE is ignored.
    begin
      exp_t e;
      int   n;
      int   d0;
      d0 = done_cnt;
      @(negedge CLK);
      START  = 1'b1;
      DATA   = 8'hF0;
      AMOUNT = 8'h05;
      e.val  = 8'h1E;
      e.due  = cyc + 1 + 5;
      sb.push_back(e);
      @(negedge CLK);
      START = 1'b0;
      repeat (2) @(negedge CLK);
      START  = 1'b1;
      DATA   = 8'h0F;
      AMOUNT = 8'h01;
      @(negedge CLK);
      START = 1'b0;
      n = 0;
      while (BUSY === 1'b1 && n < 20) begin
        n++;
        @(negedge CLK);
      end
      check("lock_idle_timeout", (n < 20), 1'b1);
      repeat (5) @(negedge CLK);
      check("lock_done_count", done_cnt - d0, 1);
      check("lock_hold", OUT, 8'h1E);
    end

    // Back-to-back with START held high: one op every 4 cycles.
    begin
      exp_t e;
      int   k;
      int   n;
      @(negedge CLK);
      START  = 1'b1;
      DATA   = 8'hC3;
      AMOUNT = 8'h02;
      k = cyc + 1;
      for (int j = 0; j < 3; j++) begin
        e.val = 8'h0F;
        e.due = k + 4 * j + 2;
        sb.push_back(e);
      end
      for (int i = 0; i < 9; i++) begin
        @(negedge CLK);
        check("b2b_busy", BUSY, ((i % 4) != 3));
      end
      START = 1'b0;
      n = 0;
      while ((BUSY === 1'b1 || sb.size() != 0) && n < 20) begin
        n++;
        @(negedge CLK);
      end
      check("b2b_drained", sb.size(), 0);
    end

    // Asynchronous reset in the middle of an operation.
    begin
      int d0;
      @(negedge CLK);
      d0     = done_cnt;
      START  = 1'b1;
      DATA   = 8'hAA;
      AMOUNT = 8'h06;
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(negedge CLK);
      check("mid_busy_before", BUSY, 1'b1);
      #2;
      RESET = 1'b0;
      #1;
      check("mid_rst_out", OUT, 8'h00);
      check("mid_rst_busy", BUSY, 1'b0);
      check("mid_rst_done", DONE, 1'b0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      repeat (10) @(negedge CLK);
      check("mid_no_done", done_cnt - d0, 0);
      check("mid_out_after", OUT, 8'h00);
    end

    check("total_done", done_cnt, 9);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
